friet_permutation_protected_iter: RTL and testbench
===================================================

# friet_permutation_protected_iter

Iterative, parametrised Friet-PC protected permutation core. It holds the 4×128-bit protected state (a, b, c, d) in a register and applies ROUNDS_PER_CYCLE chained protected rounds per clock until NUM_ROUNDS rounds are done. It generates its own round constants and uses valid/ready handshakes on input and output. It sits between the Friet AEAD/duplex controller and the state storage, replacing the fully combinational round usage.

## Interface
- NUM_ROUNDS, 24, total rounds applied; 1..24, must be a multiple of ROUNDS_PER_CYCLE.
- ROUNDS_PER_CYCLE, 1, chained round instances per cycle; legal values are divisors of NUM_ROUNDS.
- clk  input  1  rising-edge clock.
- arstn  input  1  reset; one clock; reset is asynchronous and active-low.
- din  input  512  initial state {a,b,c,d}; a = [511:384], d = [127:0].
- din_valid  input  1  din is valid.
- din_ready  output  1  core idle and accepting.
- dout  output  512  permuted state {a,b,c,d}; forced to 0 whenever dout_valid=0.
- dout_valid  output  1  result available.
- dout_ready  input  1  consumer accepts result.
- abort  input  1  present only with FRIET_PERM_ABORT_EN.

## Operation
- Round datapath: ROUNDS_PER_CYCLE instances of friet_permutation_protected_round, chained. Round r uses constants rc_c = RC_C[r] and rc_d = RC_D[r], 5 bits each, from the Friet-PC constant table (indices 0..23, held in a case-based ROM inside this block).
- Round function, with <<< meaning rotate-left and xaon(x,y,z) = (x&y)^z:
  - Constant injection: c bit 4j ^= rc_c[j] when rc_c[4]=0; c bit 4j+16 ^= rc_c[j] when rc_c[4]=1 (j = 0..3). d is treated the same way with rc_d.
  - f1 = (a<<<1)^c
  - f2 = (a<<<1)^b
  - s1 = (f1<<<80)^a
  - s2 = (f1<<<80)^f2
  - n = (s1<<<67)&(s2<<<36)
  - Outputs: a' = n^d, b' = s2, c' = s1, d' = n^f1.
- FSM states:
  - IDLE: din_ready=1. On din_valid, load din into the state register, set round_idx=0, go to RUN.
  - RUN: each cycle, state ← ROUNDS_PER_CYCLE rounds starting at round_idx, and round_idx += ROUNDS_PER_CYCLE. When round_idx+ROUNDS_PER_CYCLE == NUM_ROUNDS, go to DONE on that same edge.
  - DONE: dout_valid=1 and dout = state register. On dout_ready, clear the state register to 0 and go to IDLE.
- din_valid outside IDLE is ignored; din_ready=0 there.
- A new load is never accepted in the cycle DONE exits; there is always one IDLE cycle between jobs.
- round_idx is a 5-bit counter. It never exceeds NUM_ROUNDS-ROUNDS_PER_CYCLE during RUN and does not wrap.
- Reset values: state IDLE, state register 0, round_idx 0, din_ready 1, dout_valid 0, dout 0.
- Reset asserted mid-RUN or in DONE discards the job. No partial result is ever presented.

## Timing
- Accepting edge: the edge where din_valid=1 in IDLE.
- dout_valid rises C = NUM_ROUNDS/ROUNDS_PER_CYCLE edges after the accepting edge.
- Defaults (24 rounds, 1 per cycle): latency 24 cycles, throughput one job per C+2 cycles with dout_ready held high.
- Under backpressure, dout_valid and dout stay constant until the dout_ready edge.
- din_ready returns high the cycle after the dout transfer.
- Critical path is ROUNDS_PER_CYCLE round instances plus the constant mux. The register output feeds the rounds directly.

## Configuration
- FRIET_PERM_ABORT_EN defined:
  - The abort port exists.
  - abort=1 at any edge forces IDLE, round_idx=0 and state register=0.
  - abort has priority over a din load and over a dout transfer in the same cycle; that transfer is void.
- FRIET_PERM_ABORT_EN undefined: no abort port and no abort logic; the FSM behaves exactly as above without abort.

## Test plan
- Defaults, din=0, dout_ready=1 → dout_valid exactly 24 cycles after accept; dout equals the golden Friet-PC C-model output for the all-zero state; din_ready=0 throughout RUN/DONE.
- ROUNDS_PER_CYCLE=4, random din → dout_valid after 6 cycles; dout matches the golden model and the ROUNDS_PER_CYCLE=1 build bit-for-bit.
- dout_ready low for 10 cycles in DONE → dout_valid stays 1 and dout is stable; after the transfer, dout=0 and din_ready=1 on the next cycle.
- din_valid pulsed during RUN with different data → ignored; the result matches the first job.
- arstn low at round 11 → all outputs at reset values immediately (asynchronously); the next job completes correctly.
- FRIET_PERM_ABORT_EN build: abort at RUN cycle 5 → IDLE next cycle and no dout_valid. abort together with dout_valid&dout_ready → state cleared and the core is back in IDLE.

Source files
------------

// File: rtl/friet_permutation_protected_iter.sv
// Iterative Friet-PC permutation core: ROUNDS_PER_CYCLE chained rounds per clock, valid/ready on both sides.
// Define FRIET_PERM_ABORT_EN to add the abort port and its clearing logic.
module friet_permutation_protected_iter #(
    parameter int unsigned NUM_ROUNDS       = 24,
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic [511:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [511:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready
`ifdef FRIET_PERM_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic [4:0] RoundStep = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LastIdx   = 5'(NUM_ROUNDS - ROUNDS_PER_CYCLE);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 24 || ROUNDS_PER_CYCLE < 1 ||
        (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("friet_permutation_protected_iter: illegal NUM_ROUNDS/ROUNDS_PER_CYCLE");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [511:0] st_q, st_d;
    logic [4:0]   round_q, round_d;
    logic [511:0] rounds_out;

    // {rc_c, rc_d} per round index
    function automatic logic [9:0] rc_rom(input logic [4:0] idx);
        logic [9:0] rc;
        case (idx)
            5'd0:    rc = {5'h0F, 5'h19};
            5'd1:    rc = {5'h1E, 5'h02};
            5'd2:    rc = {5'h0D, 5'h14};
            5'd3:    rc = {5'h1A, 5'h08};
            5'd4:    rc = {5'h05, 5'h11};
            5'd5:    rc = {5'h1B, 5'h03};
            5'd6:    rc = {5'h06, 5'h17};
            5'd7:    rc = {5'h1C, 5'h0F};
            5'd8:    rc = {5'h09, 5'h1E};
            5'd9:    rc = {5'h12, 5'h0D};
            5'd10:   rc = {5'h04, 5'h1A};
            5'd11:   rc = {5'h18, 5'h05};
            5'd12:   rc = {5'h01, 5'h1B};
            5'd13:   rc = {5'h13, 5'h06};
            5'd14:   rc = {5'h07, 5'h1C};
            5'd15:   rc = {5'h1F, 5'h09};
            5'd16:   rc = {5'h0E, 5'h12};
            5'd17:   rc = {5'h1D, 5'h04};
            5'd18:   rc = {5'h0A, 5'h18};
            5'd19:   rc = {5'h15, 5'h01};
            5'd20:   rc = {5'h0B, 5'h13};
            5'd21:   rc = {5'h16, 5'h07};
            5'd22:   rc = {5'h0C, 5'h1F};
            5'd23:   rc = {5'h19, 5'h0E};
            default: rc = '0;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] rotl(input logic [127:0] x, input int unsigned n);
        return (x << n) | (x >> (128 - n));
    endfunction

    // rc[4] selects nibble positions 16..28 instead of 0..12
    function automatic logic [127:0] inject(input logic [127:0] x, input logic [4:0] rc);
        logic [15:0] nib;
        nib = {3'b0, rc[3], 3'b0, rc[2], 3'b0, rc[1], 3'b0, rc[0]};
        return x ^ {96'b0, rc[4] ? nib : 16'b0, rc[4] ? 16'b0 : nib};
    endfunction

    function automatic logic [511:0] friet_round(input logic [511:0] s, input logic [9:0] rc);
        logic [127:0] a, b, c, d, f1, f2, s1, s2, n;
        a  = s[511:384];
        b  = s[383:256];
        c  = inject(s[255:128], rc[9:5]);
        d  = inject(s[127:0], rc[4:0]);
        f1 = rotl(a, 1) ^ c;
        f2 = rotl(a, 1) ^ b;
        s1 = rotl(f1, 80) ^ a;
        s2 = rotl(f1, 80) ^ f2;
        n  = rotl(s1, 67) & rotl(s2, 36);
        return {n ^ d, s2, s1, n ^ f1};
    endfunction

    for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
        logic [511:0] in_s, out_s;
        if (k == 0) begin : g_first
            assign in_s = st_q;
        end else begin : g_next
            assign in_s = g_round[k-1].out_s;
        end
        assign out_s = friet_round(in_s, rc_rom(round_q + 5'(k)));
    end
    assign rounds_out = g_round[ROUNDS_PER_CYCLE-1].out_s;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            fsm_q   <= StIdle;
            st_q    <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        round_d = round_q;
        unique case (fsm_q)
            StIdle: begin
                if (din_valid) begin
                    fsm_d   = StRun;
                    st_d    = din;
                    round_d = '0;
                end
            end
            StRun: begin
                st_d = rounds_out;
                if (round_q == LastIdx) begin
                    fsm_d   = StDone;
                    round_d = '0;
                end else begin
                    round_d = round_q + RoundStep;
                end
            end
            StDone: begin
                if (dout_ready) begin
                    fsm_d = StIdle;
                    st_d  = '0;
                end
            end
            default: begin
                fsm_d   = StIdle;
                st_d    = '0;
                round_d = '0;
            end
        endcase
`ifdef FRIET_PERM_ABORT_EN
        // Abort wins over any load or result transfer in the same cycle
        if (abort) begin
            fsm_d   = StIdle;
            st_d    = '0;
            round_d = '0;
        end
`endif
    end

    always_comb begin
        din_ready  = (fsm_q == StIdle);
        dout_valid = (fsm_q == StDone);
        dout       = (fsm_q == StDone) ? st_q : '0;
    end

endmodule

// File: tb/tb_friet_permutation_protected_iter.sv
// Scoreboard bench for friet_permutation_protected_iter: 1-round and 4-round-per-cycle instances.
// Abort scenarios are exercised when FRIET_PERM_ABORT_EN is defined.
module tb_friet_permutation_protected_iter;

    logic         clk = 1'b0;
    logic         arstn = 1'b0;
    logic [511:0] din1 = '0, din4 = '0;
    logic         din_valid1 = 1'b0, din_valid4 = 1'b0;
    logic         din_ready1, din_ready4;
    logic [511:0] dout1, dout4;
    logic         dout_valid1, dout_valid4;
    logic         dout_ready1 = 1'b1, dout_ready4 = 1'b1;
`ifdef FRIET_PERM_ABORT_EN
    logic         abort1 = 1'b0, abort4 = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] exp1_q[$];
    logic [511:0] exp4_q[$];
    logic [4:0]   rcc_t[24];
    logic [4:0]   rcd_t[24];

    always #5 clk = ~clk;

    friet_permutation_protected_iter #(
        .NUM_ROUNDS      (24),
        .ROUNDS_PER_CYCLE(1)
    ) dut1 (
        .clk       (clk),
        .arstn     (arstn),
        .din       (din1),
        .din_valid (din_valid1),
        .din_ready (din_ready1),
        .dout      (dout1),
        .dout_valid(dout_valid1),
        .dout_ready(dout_ready1)
`ifdef FRIET_PERM_ABORT_EN
        ,
        .abort     (abort1)
`endif
    );

    friet_permutation_protected_iter #(
        .NUM_ROUNDS      (24),
        .ROUNDS_PER_CYCLE(4)
    ) dut4 (
        .clk       (clk),
        .arstn     (arstn),
        .din       (din4),
        .din_valid (din_valid4),
        .din_ready (din_ready4),
        .dout      (dout4),
        .dout_valid(dout_valid4),
        .dout_ready(dout_ready4)
`ifdef FRIET_PERM_ABORT_EN
        ,
        .abort     (abort4)
`endif
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Constants from the 4-bit LFSR stream s[n+4] = s[n] ^ s[n+3], seeded 1111
    task automatic init_rc();
        bit s[40];
        for (int n = 0; n < 4; n++) s[n] = 1'b1;
        for (int n = 0; n < 36; n++) s[n+4] = s[n] ^ s[n+3];
        for (int i = 0; i < 24; i++) begin
            rcc_t[i] = {i[0], s[i], s[i+1], s[i+2], s[i+3]};
            rcd_t[i] = {~i[0], s[i+8], s[i+9], s[i+10], s[i+11]};
        end
    endtask

    function automatic logic [127:0] m_rot(input logic [127:0] x, input int n);
        logic [127:0] y;
        for (int i = 0; i < 128; i++) y[i] = x[(i - n + 128) % 128];
        return y;
    endfunction

    function automatic logic [511:0] model(input logic [511:0] x, input int nr);
        logic [127:0] a, b, c, d, f1, f2, s1, s2, n;
        logic [511:0] st;
        st = x;
        for (int r = 0; r < nr; r++) begin
            a = st[511:384]; b = st[383:256]; c = st[255:128]; d = st[127:0];
            for (int j = 0; j < 4; j++) begin
                c[(rcc_t[r][4] ? 16 : 0) + 4 * j] ^= rcc_t[r][j];
                d[(rcd_t[r][4] ? 16 : 0) + 4 * j] ^= rcd_t[r][j];
            end
            f1 = m_rot(a, 1) ^ c;
            f2 = m_rot(a, 1) ^ b;
            s1 = m_rot(f1, 80) ^ a;
            s2 = m_rot(f1, 80) ^ f2;
            n  = m_rot(s1, 67) & m_rot(s2, 36);
            st = {n ^ d, s2, s1, n ^ f1};
        end
        return st;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic rdy(input int w);
        return (w != 0) ? din_ready4 : din_ready1;
    endfunction

    function automatic logic vld(input int w);
        return (w != 0) ? dout_valid4 : dout_valid1;
    endfunction

    function automatic logic [511:0] dout_of(input int w);
        return (w != 0) ? dout4 : dout1;
    endfunction

    task automatic drive(input int w, input logic [511:0] data, input logic v);
        if (w != 0) begin din4 = data; din_valid4 = v; end
        else begin din1 = data; din_valid1 = v; end
    endtask

    task automatic set_rr(input int w, input logic r);
        if (w != 0) dout_ready4 = r;
        else dout_ready1 = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One job: accept, latency, ready low while busy, scoreboard compare, optional backpressure
    task automatic run_job(input int w, input logic [511:0] data, input int hold, input bit poke);
        int           lat;
        bit           rdy_bad;
        logic [511:0] exp;
        check("idle_ready", 512'(rdy(w)), 512'(1));
        set_rr(w, hold == 0);
        drive(w, data, 1'b1);
        if (w != 0) exp4_q.push_back(model(data, 24));
        else exp1_q.push_back(model(data, 24));
        tick();
        drive(w, '0, 1'b0);
        lat = 0;
        rdy_bad = 0;
        while (!vld(w) && lat < 100) begin
            if (rdy(w)) rdy_bad = 1;
            if (poke && lat == 3) drive(w, ~data, 1'b1);
            if (poke && lat == 5) drive(w, '0, 1'b0);
            tick();
            lat++;
        end
        check("latency", 512'(lat), 512'((w != 0) ? 6 : 24));
        check("ready_low_run", 512'(rdy_bad), 512'(0));
        check("ready_low_done", 512'(rdy(w)), 512'(0));
        exp = (w != 0) ? exp4_q[0] : exp1_q[0];
        check("dout", dout_of(w), exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 512'(vld(w)), 512'(1));
            check("hold_dout", dout_of(w), exp);
        end
        if (w != 0) void'(exp4_q.pop_front());
        else void'(exp1_q.pop_front());
        set_rr(w, 1'b1);
        tick();
        check("post_valid", 512'(vld(w)), 512'(0));
        check("post_dout", dout_of(w), 512'(0));
        check("post_ready", 512'(rdy(w)), 512'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] r;
        init_rc();
        #1;
        check("rst_ready", 512'(din_ready1), 512'(1));
        check("rst_valid", 512'(dout_valid1), 512'(0));
        check("rst_dout", dout1, 512'(0));
        tick();
        tick();
        #2 arstn = 1'b1;
        tick();

        run_job(0, '0, 0, 0);
        run_job(0, rand512(), 10, 0);
        run_job(0, rand512(), 0, 1);

        // Asynchronous reset at round 11 discards the job
        drive(0, rand512(), 1'b1);
        tick();
        drive(0, '0, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        #2 arstn = 1'b0;
        #1;
        check("arst_ready", 512'(din_ready1), 512'(1));
        check("arst_valid", 512'(dout_valid1), 512'(0));
        check("arst_dout", dout1, 512'(0));
        tick();
        #2 arstn = 1'b1;
        tick();
        run_job(0, rand512(), 0, 0);

        r = rand512();
        run_job(4, r, 0, 0);
        run_job(0, r, 0, 0);
        run_job(4, rand512(), 3, 0);

`ifdef FRIET_PERM_ABORT_EN
        drive(0, rand512(), 1'b1);
        tick();
        drive(0, '0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("abort_ready", 512'(din_ready1), 512'(1));
        begin
            bit seen = 0;
            for (int i = 0; i < 30; i++) begin
                if (dout_valid1) seen = 1;
                tick();
            end
            check("abort_no_valid", 512'(seen), 512'(0));
        end

        set_rr(0, 1'b0);
        drive(0, rand512(), 1'b1);
        tick();
        drive(0, '0, 1'b0);
        for (int i = 0; i < 40 && !dout_valid1; i++) tick();
        check("abort_done_valid", 512'(dout_valid1), 512'(1));
        set_rr(0, 1'b1);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("abort_xfer_valid", 512'(dout_valid1), 512'(0));
        check("abort_xfer_dout", dout1, 512'(0));
        check("abort_xfer_ready", 512'(din_ready1), 512'(1));
        run_job(0, rand512(), 0, 0);
`endif

        check("sb_empty1", 512'(exp1_q.size()), 512'(0));
        check("sb_empty4", 512'(exp4_q.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
